// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   PC_CTRL_*     : next-PC select encodings driven by the control unit
//   fetch_state_t : fetch FSM states used by instruction_fetch_unit
package cpu_pkg;

  localparam logic [3:0] PC_CTRL_SEQ    = 4'b0000;
  localparam logic [3:0] PC_CTRL_JUMP   = 4'b0001;
  localparam logic [3:0] PC_CTRL_JR     = 4'b0010;
  localparam logic [3:0] PC_CTRL_BRANCH = 4'b0011;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// next_pc_calc: purely combinational next-PC selection.
//   pc_plus4    in  32  current PC + 4
//   instruction in  32  held instruction (target field, imm, beq/bne bit)
//   pc_control  in  4   select: seq / j / jr / branch (other codes = seq)
//   alu_zero    in  1   ALU zero flag
//   reg_target  in  32  rs value for jr
//   next_pc     out 32  PC to commit on advance
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instruction,
  input  logic [3:0]  pc_control,
  input  logic        alu_zero,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc
);

  logic [31:0] imm_off;
  logic        taken;
  logic        unused_opcode;

  // Word offset: sign-extend imm16 and scale by 4; adds wrap modulo 2^32.
  assign imm_off = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  // instruction[26] distinguishes bne (1) from beq (0).
  assign taken   = alu_zero ^ instruction[26];
  assign unused_opcode = &{1'b0, instruction[31:27]};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_control)
      PC_CTRL_JUMP:   next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
      PC_CTRL_JR:     next_pc = reg_target;
      PC_CTRL_BRANCH: next_pc = taken ? (pc_plus4 + imm_off) : pc_plus4;
      default:        next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches over a req/ack port with
// variable latency, and holds each instruction until the core advances.
//   clk, rst_n              clock, async active-low reset
//   imem_req/addr/ack/rdata instruction memory fetch port
//   instruction/instr_valid held word to control unit and datapath
//   advance                 core done with held word; commit next PC
//   pc_control, alu_zero,
//   reg_target              next-PC selection inputs
//   pc_out, pc_plus4        current PC and PC+4
//   fetch_err               sticky misaligned-jr flag
// Optional feature macro IFU_MISALIGN_TRAP_EN: when defined, a jr to a
// non-word-aligned target is forced aligned and sets fetch_err; otherwise
// fetch_err is 0 and jr targets pass through unmodified.
//
// state | meaning
// RST   | first cycle after reset, no request
// FETCH | request outstanding at pc_out, waiting for imem_ack
// HOLD  | instruction valid, waiting for advance
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        advance,
  input  logic [3:0]  pc_control,
  input  logic        alu_zero,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic         req_q;
  logic [31:0]  next_pc;
  logic [31:0]  pc_load;

  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;

  next_pc_calc u_next_pc_calc (
    .pc_plus4    (pc_plus4),
    .instruction (instr_q),
    .pc_control  (pc_control),
    .alu_zero    (alu_zero),
    .reg_target  (reg_target),
    .next_pc     (next_pc)
  );

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;

  assign misalign  = (pc_control == PC_CTRL_JR) && (reg_target[1:0] != 2'b00);
  assign pc_load   = misalign ? {reg_target[31:2], 2'b00} : next_pc;
  assign fetch_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == HOLD && advance && misalign) begin
      err_q <= 1'b1;
    end
  end
`else
  assign pc_load   = next_pc;
  assign fetch_err = 1'b0;
`endif

  // imem_req is registered so it reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state)
        RST: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            pc_q    <= pc_load;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= FETCH;
          end
        end
        default: begin
          state <= RST;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        advance = 1'b0;
  logic [3:0]  pc_control = 4'h0;
  logic        alu_zero = 1'b0;
  logic [31:0] reg_target = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .advance     (advance),
    .pc_control  (pc_control),
    .alu_zero    (alu_zero),
    .reg_target  (reg_target),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
  );

  typedef struct {
    logic [31:0] setup_pc;
    logic [31:0] instr;
    logic [3:0]  ctrl;
    logic        zero;
    logic [31:0] target;
    logic [31:0] exp_pc;
  } vec_t;

  localparam int NV = 11;
  vec_t        vecs [NV];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Waits for a request, checks its address against the scoreboard, optionally
  // stalls the ack (pulsing advance, which must be ignored), then returns data.
  task automatic fetch_word(input logic [31:0] data, input int delay, input bit adv_noise);
    logic [31:0] exp_addr;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_wait", 32'(imem_req), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1 entry");
      exp_addr = 32'h0;
    end else begin
      exp_addr = exp_q.pop_front();
    end
    chk("imem_addr", imem_addr, exp_addr);
    chk("pc_out", pc_out, exp_addr);
    chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    for (int i = 0; i < delay; i++) begin
      advance = adv_noise;
      @(posedge clk); #1;
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, exp_addr);
    end
    advance    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("instruction", instruction, data);
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("req_dropped", 32'(imem_req), 32'd0);
  endtask

  task automatic do_advance(input logic [3:0] ctrl, input logic zero,
                            input logic [31:0] target, input logic [31:0] exp);
    pc_control = ctrl;
    alu_zero   = zero;
    reg_target = target;
    advance    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    advance = 1'b0;
    chk("valid_cleared", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] jr_exp;
    logic [31:0] seq_exp;
    logic [31:0] got;

    vecs[0]  = '{32'h0000_0100, 32'h1000_0004, PC_CTRL_BRANCH, 1'b1, 32'hDEAD_0000, 32'h0000_0114};
    vecs[1]  = '{32'h0000_0100, 32'h1000_0004, PC_CTRL_BRANCH, 1'b0, 32'hDEAD_0000, 32'h0000_0104};
    vecs[2]  = '{32'h0000_0100, 32'h1400_0004, PC_CTRL_BRANCH, 1'b1, 32'hDEAD_0000, 32'h0000_0104};
    vecs[3]  = '{32'h0000_0100, 32'h1400_0004, PC_CTRL_BRANCH, 1'b0, 32'hDEAD_0000, 32'h0000_0114};
    vecs[4]  = '{32'h0000_0100, 32'h1000_FFFF, PC_CTRL_BRANCH, 1'b1, 32'hDEAD_0000, 32'h0000_0100};
    vecs[5]  = '{32'h0000_0100, 32'h0800_0400, PC_CTRL_JUMP,   1'b0, 32'hDEAD_0000, 32'h0000_1000};
    vecs[6]  = '{32'h0000_0100, 32'h0000_0000, PC_CTRL_JR,     1'b0, 32'h0000_2000, 32'h0000_2000};
    vecs[7]  = '{32'hFFFF_FFFC, 32'h1000_0004, PC_CTRL_SEQ,    1'b1, 32'hDEAD_0000, 32'h0000_0000};
    vecs[8]  = '{32'h0000_0200, 32'h1000_0004, 4'b0111,        1'b1, 32'hDEAD_0000, 32'h0000_0204};
    vecs[9]  = '{32'h0000_0000, 32'h1000_FFF0, PC_CTRL_BRANCH, 1'b1, 32'hDEAD_0000, 32'hFFFF_FFC4};
    vecs[10] = '{32'hF000_0000, 32'h0BFF_FFFF, PC_CTRL_JUMP,   1'b0, 32'hDEAD_0000, 32'hFFFF_FFFC};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_state_no_req", 32'(imem_req), 32'd0);

    exp_q.push_back(32'h0);
    fetch_word(32'h2008_0005, 0, 1'b0);
    do_advance(PC_CTRL_SEQ, 1'b0, 32'hDEAD_BEEC, 32'h0000_0004);
    fetch_word(32'h0000_0000, 0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      do_advance(PC_CTRL_JR, 1'b0, vecs[i].setup_pc, vecs[i].setup_pc);
      fetch_word(vecs[i].instr, 0, 1'b0);
      do_advance(vecs[i].ctrl, vecs[i].zero, vecs[i].target, vecs[i].exp_pc);
      fetch_word(32'h0000_0000, 0, 1'b0);
    end

    // Delayed ack with advance pulsed during FETCH.
    do_advance(PC_CTRL_JR, 1'b0, 32'h0000_0300, 32'h0000_0300);
    fetch_word(32'hAAAA_5555, 3, 1'b1);

    // Stray ack in HOLD must not disturb the held word.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("stray_ack_instr", instruction, 32'hAAAA_5555);
    chk("stray_ack_valid", 32'(instr_valid), 32'd1);
    chk("stray_ack_req", 32'(imem_req), 32'd0);

`ifdef IFU_MISALIGN_TRAP_EN
    jr_exp = 32'h0000_2000;
    do_advance(PC_CTRL_JR, 1'b0, 32'h0000_2002, jr_exp);
    chk("misalign_err", 32'(fetch_err), 32'd1);
`else
    jr_exp = 32'h0000_2002;
    do_advance(PC_CTRL_JR, 1'b0, 32'h0000_2002, jr_exp);
    chk("misalign_err", 32'(fetch_err), 32'd0);
`endif
    fetch_word(32'h0000_0000, 0, 1'b0);

    // Reset during FETCH, with a simultaneous ack.
    seq_exp = jr_exp + 32'd4;
    do_advance(PC_CTRL_SEQ, 1'b0, 32'h0, seq_exp);
    got = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk("midfetch_req", 32'(imem_req), 32'd1);
    chk("midfetch_addr", imem_addr, got);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_err", 32'(fetch_err), 32'd0);
    @(posedge clk); #1;
    chk("rst_wins_valid", 32'(instr_valid), 32'd0);
    chk("rst_wins_instr", instruction, 32'h0);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    fetch_word(32'h0000_0005, 0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
